// File: rtl/pwm_adc_pkg.sv
// Shared types and helpers for the multiplexed PWM-ADC scan controller.
// Holds the sequencer state encoding and the channel priority picker.
package pwm_adc_pkg;

  localparam int ADC_W = 8;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_DISCARD = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_OUTPUT  = 3'd4,
    ST_NEXT    = 3'd5
  } state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } ch_pick_t;

  // Lowest set bit of mask at or above 'from'; scanning downward leaves the lowest hit.
  function automatic ch_pick_t pick_channel(input logic [15:0] mask, input logic [4:0] from);
    ch_pick_t p;
    p = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (mask[i-1] && (5'(i - 1) >= from)) begin
        p.found = 1'b1;
        p.idx   = 4'(i - 1);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/pwm_adc_avg.sv
// Sample accumulator for one channel: sums 2^AVG_LOG2 conversions and
// exposes the truncated average including the sample arriving this cycle.
module pwm_adc_avg
  import pwm_adc_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sample,
  input  logic [ADC_W-1:0] data,
  output logic [ADC_W-1:0] avg,
  output logic             last
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  typedef logic [AVG_LOG2:0] cnt_t;
  localparam cnt_t LAST_CNT = cnt_t'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum;
  cnt_t             cnt_q;

  always_comb begin
    sum  = acc_q + ACC_W'(data);
    avg  = sum[AVG_LOG2 +: ADC_W];
    last = (cnt_q == LAST_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (sample) begin
      acc_q <= sum;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_adc_scan_ctrl.sv
// Scan sequencer sharing one PWM tracking ADC across NUM_CH mux inputs:
// settle, discard stale conversions, average, and emit one tagged result per channel.
module pwm_adc_scan_ctrl
  import pwm_adc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int SETTLE_CYC  = 256,
  parameter int DISCARD     = 2,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              cont_i,
  input  logic              stop_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic [ADC_W-1:0]  adc_data_i,
  input  logic              adc_done_i,
  output logic [CH_W-1:0]   mux_sel_o,
  output logic [ADC_W-1:0]  res_data_o,
  output logic [CH_W-1:0]   res_ch_o,
  output logic              res_valid_o,
  output logic              timeout_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       DISC_LAST   = 4'(DISCARD - 1);

  state_t            state;
  logic [NUM_CH-1:0] mask_q;
  logic              cont_q;
  logic [CH_W-1:0]   ch_q;
  logic [CNT_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  wd_cnt;
  logic [3:0]        disc_cnt;
  ch_pick_t          pick_low;
  ch_pick_t          pick_up;
  logic              avg_clr;
  logic              avg_sample;
  logic              avg_last;
  logic              wd_hit;
  logic [ADC_W-1:0]  avg_value;

  always_comb begin
    pick_low   = pick_channel(16'(ch_mask_i), 5'd0);
    pick_up    = pick_channel(16'(mask_q), 5'(ch_q) + 5'd1);
    avg_clr    = (state == ST_SETTLE);
    avg_sample = (state == ST_ACCUM) && adc_done_i && !stop_i;
    wd_hit     = (wd_cnt == WD_LAST);
  end

  pwm_adc_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (avg_clr),
    .sample(avg_sample),
    .data  (adc_data_i),
    .avg   (avg_value),
    .last  (avg_last)
  );

  // Results are registered on the edge that enters OUTPUT, so the strobe
  // lands in the cycle right after the final accepted conversion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      mask_q      <= '0;
      cont_q      <= 1'b0;
      ch_q        <= '0;
      settle_cnt  <= '0;
      wd_cnt      <= '0;
      disc_cnt    <= '0;
      mux_sel_o   <= '0;
      res_data_o  <= '0;
      res_ch_o    <= '0;
      res_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      res_valid_o <= 1'b0;
      if (state != ST_IDLE && stop_i) begin
        state  <= ST_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i && !stop_i && pick_low.found) begin
              mask_q     <= ch_mask_i;
              cont_q     <= cont_i;
              ch_q       <= CH_W'(pick_low.idx);
              mux_sel_o  <= CH_W'(pick_low.idx);
              settle_cnt <= '0;
              busy_o     <= 1'b1;
              state      <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              wd_cnt     <= '0;
              disc_cnt   <= '0;
              state      <= (DISCARD == 0) ? ST_ACCUM : ST_DISCARD;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_DISCARD: begin
            if (adc_done_i) begin
              wd_cnt <= '0;
              if (disc_cnt == DISC_LAST) state <= ST_ACCUM;
              else disc_cnt <= disc_cnt + 1'b1;
            end else if (wd_hit) begin
              res_data_o  <= '0;
              res_ch_o    <= ch_q;
              timeout_o   <= 1'b1;
              res_valid_o <= 1'b1;
              state       <= ST_OUTPUT;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
          ST_ACCUM: begin
            if (adc_done_i) begin
              wd_cnt <= '0;
              if (avg_last) begin
                res_data_o  <= avg_value;
                res_ch_o    <= ch_q;
                timeout_o   <= 1'b0;
                res_valid_o <= 1'b1;
                state       <= ST_OUTPUT;
              end
            end else if (wd_hit) begin
              res_data_o  <= '0;
              res_ch_o    <= ch_q;
              timeout_o   <= 1'b1;
              res_valid_o <= 1'b1;
              state       <= ST_OUTPUT;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
          ST_OUTPUT: begin
            // Ending a single scan drops busy here so it falls right after the strobe.
            if (!cont_q && !pick_up.found) busy_o <= 1'b0;
            state <= ST_NEXT;
          end
          ST_NEXT: begin
            settle_cnt <= '0;
            if (pick_up.found) begin
              ch_q      <= CH_W'(pick_up.idx);
              mux_sel_o <= CH_W'(pick_up.idx);
              state     <= ST_SETTLE;
            end else if (cont_q && pick_low.found) begin
              mask_q    <= ch_mask_i;
              ch_q      <= CH_W'(pick_low.idx);
              mux_sel_o <= CH_W'(pick_low.idx);
              state     <= ST_SETTLE;
            end else begin
              busy_o <= 1'b0;
              state  <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_adc_scan_ctrl.sv
// Self-checking bench for pwm_adc_scan_ctrl: a timeline model of each scan
// predicts every output each cycle; literal results pin the model.
module tb_pwm_adc_scan_ctrl;

  localparam int SETTLE = 8;
  localparam int DISC   = 1;
  localparam int NAVG   = 4;
  localparam int TMO    = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       stop = 1'b0;
  logic       adc_done = 1'b0;
  logic [3:0] mask = '0;
  logic [7:0] adc_data = '0;

  logic [1:0] mux_sel;
  logic [1:0] res_ch;
  logic [7:0] res_data;
  logic       res_valid;
  logic       timeout;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] e_mux = '0;
  logic [1:0] e_ch = '0;
  logic [7:0] e_data = '0;
  logic       e_valid = 1'b0;
  logic       e_to = 1'b0;
  logic       e_busy = 1'b0;
  logic       abort = 1'b0;

  logic [10:0] res_q[$];
  int          base;

  pwm_adc_scan_ctrl #(
    .NUM_CH(4),
    .CH_W(2),
    .SETTLE_CYC(SETTLE),
    .DISCARD(DISC),
    .AVG_LOG2(2),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .cont_i     (cont),
    .stop_i     (stop),
    .ch_mask_i  (mask),
    .adc_data_i (adc_data),
    .adc_done_i (adc_done),
    .mux_sel_o  (mux_sel),
    .res_data_o (res_data),
    .res_ch_o   (res_ch),
    .res_valid_o(res_valid),
    .timeout_o  (timeout),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic chk_res(input string name, input int idx, input logic [1:0] ch,
                         input logic [7:0] d, input logic to);
    if (idx >= res_q.size()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: result %0d missing, want ch%0d data %h timeout %0d", name, idx, ch, d, to);
    end else begin
      chk(name, 32'(res_q[idx]), 32'({ch, d, to}));
    end
  endtask

  function automatic int first_ch(input logic [3:0] m, input int from);
    for (int i = from; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic zero_exp();
    e_mux = '0; e_ch = '0; e_data = '0; e_valid = 1'b0; e_to = 1'b0; e_busy = 1'b0;
  endtask

  // One clock edge inside a scan; reset or stop aborts the scan timeline.
  task automatic adv();
    @(posedge clk or negedge rst_n);
    e_valid = 1'b0;
    if (!rst_n) begin
      zero_exp();
      abort = 1'b1;
    end else if (stop) begin
      abort  = 1'b1;
      e_busy = 1'b0;
    end
  endtask

  initial begin : model
    logic [3:0] lmask;
    logic       lcont;
    logic       tmo;
    int         ch, nxt, disc, ns, sum, silent;
    forever begin
      abort = 1'b0;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) zero_exp();
        else if (start && !stop && mask != 4'd0) break;
      end
      lmask  = mask;
      lcont  = cont;
      ch     = first_ch(lmask, 0);
      e_busy = 1'b1;
      e_mux  = 2'(ch);
      while (!abort) begin
        for (int i = 0; i < SETTLE && !abort; i++) adv();
        if (abort) break;
        disc = 0; ns = 0; sum = 0; silent = 0; tmo = 1'b0;
        forever begin
          adv();
          if (abort) break;
          if (adc_done) begin
            silent = 0;
            if (disc < DISC) disc++;
            else begin
              sum += int'(adc_data);
              ns++;
              if (ns == NAVG) break;
            end
          end else begin
            silent++;
            if (silent == TMO) begin
              tmo = 1'b1;
              break;
            end
          end
        end
        if (abort) break;
        e_valid = 1'b1;
        e_ch    = 2'(ch);
        e_data  = tmo ? 8'h00 : 8'(sum / NAVG);
        e_to    = tmo;
        adv();
        if (abort) break;
        nxt = first_ch(lmask, ch + 1);
        if (nxt < 0 && !lcont) begin
          e_busy = 1'b0;
          adv();
          break;
        end
        adv();
        if (abort) break;
        if (nxt < 0) begin
          lmask = mask;
          nxt   = first_ch(lmask, 0);
          if (nxt < 0) begin
            e_busy = 1'b0;
            break;
          end
        end
        ch    = nxt;
        e_mux = 2'(ch);
      end
    end
  end

  always @(negedge clk) begin
    chk("outputs", 32'({busy, mux_sel, res_valid, res_data, res_ch, timeout}),
                   32'({e_busy, e_mux, e_valid, e_data, e_ch, e_to}));
    if (res_valid) res_q.push_back({res_ch, res_data, timeout});
  end

  task automatic start_scan(input logic [3:0] m, input logic c);
    @(negedge clk);
    mask  = m;
    cont  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int pre, input int gap, input logic [39:0] vals, input int n);
    repeat (pre) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      adc_data = vals[39 - 8*i -: 8];
      adc_done = 1'b1;
      @(negedge clk);
      adc_done = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({busy, mux_sel, res_valid, res_data, res_ch, timeout}), 32'd0);
    rst_n = 1'b1;

    // Single scan over ch0/ch2; first done right after settle is discarded.
    base = res_q.size();
    start_scan(4'b0101, 1'b0);
    feed(8, 2, {8'h99, 8'h10, 8'h20, 8'h30, 8'h40}, 5);
    feed(12, 2, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE}, 5);
    repeat (6) @(negedge clk);
    #1;
    chk_res("t1_ch0", base, 2'd0, 8'h28, 1'b0);
    chk_res("t1_ch2", base + 1, 2'd2, 8'hFE, 1'b0);
    chk("t1_count", 32'(res_q.size() - base), 32'd2);
    chk("t1_busy_low", 32'(busy), 32'd0);

    // Continuous on ch3, mask switched mid-scan takes effect at the wrap.
    base = res_q.size();
    start_scan(4'b1000, 1'b1);
    feed(8, 2, {8'h00, 8'h04, 8'h04, 8'h04, 8'h04}, 5);
    repeat (6) @(negedge clk);
    mask = 4'b0011;
    feed(6, 2, {8'h00, 8'h08, 8'h08, 8'h08, 8'h08}, 5);
    feed(12, 2, {8'h00, 8'h01, 8'h02, 8'h03, 8'h04}, 5);
    feed(12, 2, {8'h00, 8'h10, 8'h11, 8'h12, 8'h13}, 5);
    feed(12, 2, {8'h00, 8'h07, 8'h07, 8'h07, 8'h07}, 5);
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    #1;
    chk("t3_stop_busy", 32'(busy), 32'd0);
    chk_res("t3_r0", base, 2'd3, 8'h04, 1'b0);
    chk_res("t3_r1", base + 1, 2'd3, 8'h08, 1'b0);
    chk_res("t3_r2", base + 2, 2'd0, 8'h02, 1'b0);
    chk_res("t3_r3", base + 3, 2'd1, 8'h11, 1'b0);
    chk_res("t3_r4", base + 4, 2'd0, 8'h07, 1'b0);

    // Silent ch1 times out; ch2 still converts.
    base = res_q.size();
    start_scan(4'b0110, 1'b0);
    feed(85, 2, {8'h33, 8'h10, 8'h10, 8'h20, 8'h20}, 5);
    repeat (6) @(negedge clk);
    #1;
    chk_res("t4_ch1_timeout", base, 2'd1, 8'h00, 1'b1);
    chk_res("t4_ch2", base + 1, 2'd2, 8'h18, 1'b0);
    chk("t4_busy_low", 32'(busy), 32'd0);

    // Stop after two accumulated samples, then start and stop together.
    base = res_q.size();
    start_scan(4'b0001, 1'b0);
    feed(8, 2, {8'h55, 8'h10, 8'h20, 8'h00, 8'h00}, 3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t5_stop_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    #1;
    chk("t5_no_result", 32'(res_q.size() - base), 32'd0);
    @(negedge clk);
    mask  = 4'b0001;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("t5_start_stop_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t5_still_idle", 32'(busy), 32'd0);

    // Asynchronous reset in SETTLE, then a start with an empty mask.
    start_scan(4'b0100, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_mux", 32'(mux_sel), 32'd0);
    chk("t6_rst_result", 32'({res_valid, res_data, res_ch, timeout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_scan(4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    chk("t6_zero_mask_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
